// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package add_sub_pkg;

  localparam int unsigned ADD_SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the per-bit arithmetic core of serial_add_sub.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, one bit per clock, LSB first; fixed WIDTH-cycle latency.
// Optional signed-overflow output ovf enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Sum bits enter a_q from the MSB side, so after WIDTH shifts a_q holds the full result.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d     = {fa_s, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          result_d = {fa_s, a_q[WIDTH-1:1]};
          cout_d   = fa_co;
`ifdef SERIAL_ADD_SUB_OVF_EN
          ovf_d    = carry_q ^ fa_co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=8; ovf checked when SERIAL_ADD_SUB_OVF_EN is defined.
module tb_serial_add_sub;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    string        name;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic         ovf;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, int'(result), int'(e.res));
        check({e.name, "_cout"}, int'(cout), int'(e.co));
`ifdef SERIAL_ADD_SUB_OVF_EN
        check({e.name, "_ovf"}, int'(ovf), int'(e.ov));
`endif
      end
    end
  end

  // Called just after a negedge; launches an op, then waits for done and checks timing.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er,
                        input logic ec, input logic eo, input bool_chk_timing);
    exp_t e;
    int   edges;
    int   busy_cnt;
    bit   seen;
    e.res = er; e.co = ec; e.ov = eo; e.name = name;
    sb_q.push_back(e);
    sub = s; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 1;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk);
      edges++;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    if (bool_chk_timing) begin
      check({name, "_latency_edges"}, edges, W + 1);
      check({name, "_busy_cycles"}, busy_cnt, W);
    end
  endtask

  typedef bit bool_chk_timing;

  initial begin
    start = 1'b0; sub = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_cout", int'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    run_op("sub_05_03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    run_op("sub_03_05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("result_held", int'(result), 32'hFE);

    // Start pulsed mid-operation with different operands must be ignored.
    fork
      run_op("ignore_start", 1'b0, 8'h20, 8'h22, 8'h42, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #2 sub = 1'b1; a = 8'hFF; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
      end
    join

    // Back-to-back: next start issued while DONE is showing.
    run_op("b2b_sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b1);
    run_op("b2b_add_40_40", 1'b0, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    run_op("add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of SHIFT: outputs clear at once, no done pulse follows.
    @(negedge clk);
    sub = 1'b0; a = 8'h33; b = 8'h44; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_result", int'(result), 0);
    check("rst_mid_cout", int'(cout), 0);
`ifdef SERIAL_ADD_SUB_OVF_EN
    check("rst_mid_ovf", int'(ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) check("no_done_after_reset", 1, 0);
    end
    check("no_done_after_reset_busy", int'(busy), 0);
    run_op("post_rst_01_01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
